// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state
// encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_adder.sv
// Combinational ripple-carry adder built from a chain of full-adder cells.
module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign co = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shared ripple adder, WIDTH shift-and-add
// iterations, Start/Busy/Done handshake and a registered 2*WIDTH-bit product.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] P,
    output state_t             dbg_state
);

    // Handshake: Start is sampled only in IDLE; Busy stays high from the cycle
    // after an accepted Start through the Done cycle; Done pulses for one
    // cycle exactly when P takes the new product.

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    assign addend = q[0] ? m : '0;

    rca_adder #(.WIDTH(WIDTH)) u_adder (
        .a  (acc),
        .b  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    assign dbg_state = state;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                RUN: begin
                    // The carry-out becomes the new Acc MSB, so no result bit is lost.
                    acc <= {carry, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    P     <= {acc, q};
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and sweep bench for shift_add_multiplier with a Done-driven scoreboard.
module tb_shift_add_multiplier;
    import mult_pkg::*;

    localparam int W = 4;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             Busy;
    logic             Done;
    logic [2*W-1:0]   P;
    state_t           dbg_state;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;
    logic [2*W-1:0] exp_q[$];

    shift_add_multiplier #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .P         (P),
        .dbg_state (dbg_state)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse retires the oldest expected product.
    always @(posedge Clock) begin
        #1;
        if (Done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual P=%0h required no Done", P);
            end else begin
                check("product", 32'(P), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] req, input string tag);
        int n;
        exp_q.push_back(req);
        @(negedge Clock);
        A = a; B = b; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        check({tag, "_busy_rise"}, 32'(Busy), 32'd1);
        n = 0;
        while (n < 20) begin
            @(posedge Clock); #1;
            n++;
            if (Done === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(W + 1));
        check({tag, "_busy_in_done"}, 32'(Busy), 32'd1);
        @(posedge Clock); #1;
        check({tag, "_busy_fall"}, 32'(Busy), 32'd0);
        check({tag, "_done_fall"}, 32'(Done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        int cyc;
        int dc;
        int t[3];

        Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_p", 32'(P), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(posedge Clock);

        run_op(4'd15, 4'd15, 8'hE1, "max");
        run_op(4'd0,  4'd9,  8'h00, "zero_a");
        run_op(4'd9,  4'd0,  8'h00, "zero_b");
        run_op(4'd8,  4'd15, 8'h78, "carry");
        run_op(4'd13, 4'd11, 8'h8F, "mixed");

        // Start re-pulsed during RUN must be ignored.
        dc = done_count;
        exp_q.push_back(8'h0F);
        @(negedge Clock);
        A = 4'd3; B = 4'd5; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock); #1;
        A = 4'd15; B = 4'd15; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (14) @(posedge Clock);
        #2;
        check("repulse_done_count", 32'(done_count - dc), 32'd1);

        // Reset mid-operation discards the product and suppresses Done.
        dc = done_count;
        @(negedge Clock);
        A = 4'd7; B = 4'd7; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock); #1;
        Reset = 1'b1;
        #1;
        check("midreset_p", 32'(P), 32'd0);
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_done", 32'(Done), 32'd0);
        check("midreset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(posedge Clock);
        #2;
        check("midreset_no_done", 32'(done_count - dc), 32'd0);
        run_op(4'd2, 4'd3, 8'h06, "after_reset");

        // Start held high: back-to-back products every W+2 cycles.
        repeat (3) exp_q.push_back(8'h2A);
        @(negedge Clock);
        A = 4'd6; B = 4'd7; Start = 1'b1;
        k = 0; cyc = 0;
        while (cyc < 40 && k < 3) begin
            @(posedge Clock); #1;
            cyc++;
            if (Done === 1'b1) begin
                t[k] = cyc;
                k++;
                if (k == 3) Start = 1'b0;
            end
        end
        Start = 1'b0;
        check("held_done_count", 32'(k), 32'd3);
        check("held_first", 32'(t[0]), 32'(W + 2));
        check("held_interval1", 32'(t[1] - t[0]), 32'(W + 2));
        check("held_interval2", 32'(t[2] - t[1]), 32'(W + 2));
        @(posedge Clock); #1;
        check("held_busy_fall", 32'(Busy), 32'd0);

        // Exhaustive sweep against a plain arithmetic reference.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(W'(a), W'(b), (2*W)'(a * b), "sweep");
            end
        end

        n = 0;
        repeat (4) @(posedge Clock);
        #2;
        check("queue_empty", 32'(exp_q.size()), 32'(n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
